// File: rtl/lifo.sv
// Single-clock LIFO stack of 2**AWIDTH words with registered pop data and occupancy flags.
// Define LIFO_ERR_FLAGS_EN to add sticky overflow/underflow outputs ovf_o and udf_o.
module lifo #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              wrreq_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic              empty_o,
  output logic              full_o,
`ifdef LIFO_ERR_FLAGS_EN
  output logic              ovf_o,
  output logic              udf_o,
`endif
  output logic [AWIDTH:0]   usedw_o
);

  localparam int unsigned Depth = 2 ** AWIDTH;
  localparam logic [AWIDTH:0] DepthCnt = (AWIDTH + 1)'(Depth);

  logic [DWIDTH-1:0] mem_q [Depth];
  logic [AWIDTH:0]   usedw_d, usedw_q;
  logic [DWIDTH-1:0] q_d, q_q;
  logic [AWIDTH:0]   top_ptr;
  logic              push_ok, pop_ok;
  logic              empty, full;

  // Flags decode straight from the registered counter so they track usedw_o exactly.
  assign empty = (usedw_q == '0);
  assign full  = (usedw_q == DepthCnt);

  // Write has priority: a simultaneous read is dropped even when the push is refused.
  assign push_ok = wrreq_i & ~full;
  assign pop_ok  = rdreq_i & ~wrreq_i & ~empty;
  assign top_ptr = usedw_q - 1'b1;

  always_comb begin
    usedw_d = usedw_q;
    q_d     = q_q;
    if (push_ok) begin
      usedw_d = usedw_q + 1'b1;
    end else if (pop_ok) begin
      usedw_d = top_ptr;
      q_d     = mem_q[top_ptr[AWIDTH-1:0]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      usedw_q <= '0;
      q_q     <= '0;
    end else begin
      usedw_q <= usedw_d;
      q_q     <= q_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[usedw_q[AWIDTH-1:0]] <= data_i;
    end
  end

`ifdef LIFO_ERR_FLAGS_EN
  logic ovf_d, ovf_q, udf_d, udf_q;

  always_comb begin
    ovf_d = ovf_q | (wrreq_i & full);
    udf_d = udf_q | (rdreq_i & ~wrreq_i & empty);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_o = ovf_q;
  assign udf_o = udf_q;
`endif

  assign q_o     = q_q;
  assign usedw_o = usedw_q;
  assign empty_o = empty;
  assign full_o  = full;

endmodule

// File: tb/tb_lifo.sv
// Randomised bench for lifo: a queue-based stack model is compared against the DUT every cycle,
// with literal checks at the directed corner cases.
module tb_lifo;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wrreq = 1'b0;
  logic          rdreq = 1'b0;
  logic [DW-1:0] data = '0;
  logic [DW-1:0] q;
  logic          empty, full;
  logic [AW:0]   usedw;
`ifdef LIFO_ERR_FLAGS_EN
  logic          ovf, udf;
`endif

  int vectors = 0;
  int miscompares = 0;

  lifo #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .wrreq_i (wrreq),
    .data_i  (data),
    .rdreq_i (rdreq),
    .q_o     (q),
    .empty_o (empty),
    .full_o  (full),
`ifdef LIFO_ERR_FLAGS_EN
    .ovf_o   (ovf),
    .udf_o   (udf),
`endif
    .usedw_o (usedw)
  );

  always #5 clk = ~clk;

  // Behavioural model: a queue whose back is the stack top.
  logic [DW-1:0] m_stack[$];
  logic [DW-1:0] m_q = '0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stack.delete();
      m_q   = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else if (wrreq) begin
      if (m_stack.size() < DEPTH) m_stack.push_back(data);
      else m_ovf = 1'b1;
    end else if (rdreq) begin
      if (m_stack.size() > 0) m_q = m_stack.pop_back();
      else m_udf = 1'b1;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("usedw", int'(usedw), m_stack.size());
    chk("empty", int'(empty), int'(m_stack.size() == 0));
    chk("full", int'(full), int'(m_stack.size() == DEPTH));
    chk("q", int'(q), int'(m_q));
`ifdef LIFO_ERR_FLAGS_EN
    chk("ovf", int'(ovf), int'(m_ovf));
    chk("udf", int'(udf), int'(m_udf));
`endif
  end

  task automatic cyc(input bit wr, input bit rd, input logic [DW-1:0] d);
    @(negedge clk);
    #2;
    wrreq = wr;
    rdreq = rd;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] pushed [DEPTH];

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_usedw", int'(usedw), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_q", int'(q), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Fill to full
    for (int i = 0; i < DEPTH; i++) begin
      pushed[i] = DW'($urandom);
      cyc(1'b1, 1'b0, pushed[i]);
      chk("fill_usedw", int'(usedw), i + 1);
      chk("fill_full", int'(full), int'(i == DEPTH - 1));
      chk("fill_empty", int'(empty), 0);
    end

    // Push while full
    cyc(1'b1, 1'b0, 8'h3c);
    chk("ovf_usedw", int'(usedw), DEPTH);
`ifdef LIFO_ERR_FLAGS_EN
    chk("ovf_flag", int'(ovf), 1);
`endif

    // Drain with four extra pops
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, 1'b1, 8'h00);
      if (i < DEPTH) begin
        chk("pop_q", int'(q), int'(pushed[DEPTH-1-i]));
      end else begin
        chk("udf_q", int'(q), int'(pushed[0]));
        chk("udf_usedw", int'(usedw), 0);
        chk("udf_empty", int'(empty), 1);
      end
    end
`ifdef LIFO_ERR_FLAGS_EN
    chk("udf_flag", int'(udf), 1);
`endif

    // Random mixes: push-heavy then pop-heavy
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 300; i++) begin
        int  r;
        bit  wr, rd;
        r  = int'($urandom_range(99));
        wr = (phase == 0) ? (r < 70) : (r < 30);
        rd = !wr || ($urandom_range(7) == 0);
        cyc(wr, rd, DW'($urandom));
      end
    end

    // Mid-operation reset discards everything
    cyc(1'b1, 1'b0, 8'h11);
    cyc(1'b1, 1'b0, 8'h22);
    @(negedge clk);
    #2;
    wrreq = 1'b0;
    rdreq = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_usedw", int'(usedw), 0);
    chk("midrst_q", int'(q), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Simultaneous read and write at usedw=3
    cyc(1'b1, 1'b0, 8'h01);
    cyc(1'b1, 1'b0, 8'h02);
    cyc(1'b1, 1'b0, 8'h03);
    cyc(1'b0, 1'b1, 8'h00);
    chk("pre_q", int'(q), 8'h03);
    cyc(1'b1, 1'b0, 8'h04);
    chk("pre_usedw", int'(usedw), 3);
    cyc(1'b1, 1'b1, 8'hA5);
    chk("both_usedw", int'(usedw), 4);
    chk("both_q", int'(q), 8'h03);
    cyc(1'b0, 1'b1, 8'h00);
    chk("both_pop", int'(q), 8'hA5);
    cyc(1'b0, 1'b1, 8'h00);
    chk("both_pop2", int'(q), 8'h04);

    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
